// File: rtl/tod_adj_ctrl_if.sv
// ---------------------------------------------------------------------------
// tod_adj_ctrl_if
// Bundles the request handshakes (host CSR path and servo), the tod_core
// adjustment outputs and the status outputs of tod_adj_ctrl.
//
// Modports:
//   slave  - the adjustment controller: takes requests, drives tod_core
//            strobes/data and status.
//   master - the requester / consumer side (host, servo, tod_core, bench).
//
// Signals:
//   host_valid/host_ready, host_is_init, host_plus, host_sub_ns/ns/sec
//   srv_valid/srv_ready, srv_plus, srv_sub_ns, srv_ns
//   set_init_time, init_time_sub_ns/ns/sec
//   set_offset_time, plus_offset_time, offset_time_sub_ns/ns
//   busy, done, err, remaining_ns
// ---------------------------------------------------------------------------
interface tod_adj_ctrl_if #(
    parameter int TIME_WIDTH_SUB_NS = 20,
    parameter int TIME_WIDTH_NS     = 32,
    parameter int TIME_WIDTH_SEC    = 48
);
    logic                         host_valid;
    logic                         host_ready;
    logic                         host_is_init;
    logic                         host_plus;
    logic [TIME_WIDTH_SUB_NS-1:0] host_sub_ns;
    logic [TIME_WIDTH_NS-1:0]     host_ns;
    logic [TIME_WIDTH_SEC-1:0]    host_sec;

    logic                         srv_valid;
    logic                         srv_ready;
    logic                         srv_plus;
    logic [TIME_WIDTH_SUB_NS-1:0] srv_sub_ns;
    logic [TIME_WIDTH_NS-1:0]     srv_ns;

    logic                         set_init_time;
    logic [TIME_WIDTH_SUB_NS-1:0] init_time_sub_ns;
    logic [TIME_WIDTH_NS-1:0]     init_time_ns;
    logic [TIME_WIDTH_SEC-1:0]    init_time_sec;

    logic                         set_offset_time;
    logic                         plus_offset_time;
    logic [TIME_WIDTH_SUB_NS-1:0] offset_time_sub_ns;
    logic [TIME_WIDTH_NS-1:0]     offset_time_ns;

    logic                         busy;
    logic                         done;
    logic                         err;
    logic [TIME_WIDTH_NS-1:0]     remaining_ns;

    modport slave (
        input  host_valid, host_is_init, host_plus, host_sub_ns, host_ns, host_sec,
        input  srv_valid, srv_plus, srv_sub_ns, srv_ns,
        output host_ready, srv_ready,
        output set_init_time, init_time_sub_ns, init_time_ns, init_time_sec,
        output set_offset_time, plus_offset_time, offset_time_sub_ns, offset_time_ns,
        output busy, done, err, remaining_ns
    );

    modport master (
        output host_valid, host_is_init, host_plus, host_sub_ns, host_ns, host_sec,
        output srv_valid, srv_plus, srv_sub_ns, srv_ns,
        input  host_ready, srv_ready,
        input  set_init_time, init_time_sub_ns, init_time_ns, init_time_sec,
        input  set_offset_time, plus_offset_time, offset_time_sub_ns, offset_time_ns,
        input  busy, done, err, remaining_ns
    );
endinterface

// File: rtl/tod_adj_ctrl.sv
// ---------------------------------------------------------------------------
// tod_adj_ctrl
// Adjustment controller in front of tod_core. Arbitrates the host CSR path
// (fixed priority) and the servo for the adjustment interface and sequences
// the set_init_time / set_offset_time pulses.
//
// Build option: macro TOD_ADJ_SLEW_EN
//   defined     - offsets are slewed in chunks of at most MAX_STEP_NS ns per
//                 pulse, pulses spaced STEP_GAP idle cycles apart.
//   not defined - every offset is a single full-size pulse; MAX_STEP_NS and
//                 STEP_GAP are unused, remaining_ns is tied to 0.
//
// Ports:
//   clk  - single clock
//   rst  - synchronous, active-high reset
//   adj  - tod_adj_ctrl_if.slave: request handshakes, tod_core strobes/data,
//          busy/done/err status and remaining_ns
// ---------------------------------------------------------------------------
module tod_adj_ctrl #(
    parameter int TIME_WIDTH_SUB_NS = 20,
    parameter int TIME_WIDTH_NS     = 32,
    parameter int TIME_WIDTH_SEC    = 48,
    parameter int MAX_STEP_NS       = 1000,
    parameter int STEP_GAP          = 15
) (
    input  logic          clk,
    input  logic          rst,
    tod_adj_ctrl_if.slave adj
);

    localparam logic [TIME_WIDTH_NS-1:0] NS_LIMIT = TIME_WIDTH_NS'(999_999_999);

`ifdef TOD_ADJ_SLEW_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_STEP = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    localparam int                       GAP_W    = (STEP_GAP > 1) ? $clog2(STEP_GAP) : 1;
    localparam logic [TIME_WIDTH_NS-1:0] MAX_STEP = TIME_WIDTH_NS'(MAX_STEP_NS);
    localparam logic [GAP_W-1:0]         GAP_LOAD = GAP_W'(STEP_GAP - 1);
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_STEP = 2'd2
    } state_t;
`endif

    state_t                       r_state,      w_state_nxt;
    logic                         r_host_ready;
    logic                         r_dir,        w_dir_nxt;
    logic                         r_set_init,   w_set_init_nxt;
    logic [TIME_WIDTH_SUB_NS-1:0] r_init_sub,   w_init_sub_nxt;
    logic [TIME_WIDTH_NS-1:0]     r_init_ns,    w_init_ns_nxt;
    logic [TIME_WIDTH_SEC-1:0]    r_init_sec,   w_init_sec_nxt;
    logic                         r_set_off,    w_set_off_nxt;
    logic                         r_plus,       w_plus_nxt;
    logic [TIME_WIDTH_SUB_NS-1:0] r_off_sub,    w_off_sub_nxt;
    logic [TIME_WIDTH_NS-1:0]     r_off_ns,     w_off_ns_nxt;
    logic                         r_done,       w_done_nxt;
    logic                         r_err,        w_err_nxt;

    // Request selection: host wins whenever it is valid.
    logic                         w_host_acc;
    logic                         w_srv_acc;
    logic                         w_req_init;
    logic                         w_req_off;
    logic                         w_req_plus;
    logic [TIME_WIDTH_NS-1:0]     w_req_ns;
    logic [TIME_WIDTH_SUB_NS-1:0] w_req_sub;
    logic                         w_req_zero;

`ifdef TOD_ADJ_SLEW_EN
    logic [TIME_WIDTH_NS-1:0]     r_rem,        w_rem_nxt;
    logic [GAP_W-1:0]             r_gap,        w_gap_nxt;
    logic [TIME_WIDTH_NS-1:0]     w_req_step;
    logic [TIME_WIDTH_NS-1:0]     w_rem_step;
    logic [TIME_WIDTH_NS-1:0]     w_rem_left;
`else
    logic                         w_unused_cfg;
    assign w_unused_cfg = ^{32'(MAX_STEP_NS), 32'(STEP_GAP)};
`endif

    assign w_host_acc = adj.host_valid & r_host_ready;
    assign w_srv_acc  = adj.srv_valid & r_host_ready & ~adj.host_valid;
    assign w_req_init = w_host_acc & adj.host_is_init;
    assign w_req_off  = (w_host_acc & ~adj.host_is_init) | w_srv_acc;
    assign w_req_plus = w_host_acc ? adj.host_plus   : adj.srv_plus;
    assign w_req_ns   = w_host_acc ? adj.host_ns     : adj.srv_ns;
    assign w_req_sub  = w_host_acc ? adj.host_sub_ns : adj.srv_sub_ns;
    assign w_req_zero = (w_req_ns == '0) && (w_req_sub == '0);

`ifdef TOD_ADJ_SLEW_EN
    assign w_req_step = (w_req_ns > MAX_STEP) ? MAX_STEP : w_req_ns;
    assign w_rem_step = (r_rem > MAX_STEP) ? MAX_STEP : r_rem;
    assign w_rem_left = r_rem - w_rem_step;
`endif

    // Next-state and next-output logic. Outputs are computed one cycle ahead
    // and registered, so a pulse issued "at T+1" is decided during cycle T.
    always_comb begin
        w_state_nxt    = r_state;
        w_dir_nxt      = r_dir;
        w_set_init_nxt = 1'b0;
        w_init_sub_nxt = '0;
        w_init_ns_nxt  = '0;
        w_init_sec_nxt = '0;
        w_set_off_nxt  = 1'b0;
        w_plus_nxt     = 1'b0;
        w_off_sub_nxt  = '0;
        w_off_ns_nxt   = '0;
        w_done_nxt     = 1'b0;
        w_err_nxt      = 1'b0;
`ifdef TOD_ADJ_SLEW_EN
        w_rem_nxt      = r_rem;
        w_gap_nxt      = r_gap;
`endif

        case (r_state)
            ST_IDLE: begin
                if (w_req_init) begin
                    w_state_nxt    = ST_INIT;
                    w_set_init_nxt = 1'b1;
                    w_init_sub_nxt = adj.host_sub_ns;
                    w_init_ns_nxt  = adj.host_ns;
                    w_init_sec_nxt = adj.host_sec;
                    w_done_nxt     = 1'b1;
                end else if (w_req_off) begin
                    if (w_req_ns > NS_LIMIT) begin
                        w_err_nxt = 1'b1;
                    end else if (w_req_zero) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt   = ST_STEP;
                        w_set_off_nxt = 1'b1;
                        w_off_sub_nxt = w_req_sub;
                        w_plus_nxt    = w_req_plus;
                        w_dir_nxt     = w_req_plus;
`ifdef TOD_ADJ_SLEW_EN
                        w_off_ns_nxt  = w_req_step;
                        w_rem_nxt     = w_req_ns;
`else
                        w_off_ns_nxt  = w_req_ns;
`endif
                    end
                end
            end

            ST_INIT: begin
                w_state_nxt = ST_IDLE;
            end

            ST_STEP: begin
`ifdef TOD_ADJ_SLEW_EN
                // The pulse visible now carried w_rem_step; retire it.
                w_rem_nxt = w_rem_left;
                if (w_rem_left == '0) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_state_nxt = ST_GAP;
                    w_gap_nxt   = GAP_LOAD;
                    w_plus_nxt  = r_dir;
                end
`else
                w_state_nxt = ST_IDLE;
                w_done_nxt  = 1'b1;
`endif
            end

`ifdef TOD_ADJ_SLEW_EN
            ST_GAP: begin
                w_plus_nxt = r_dir;
                if (r_gap == '0) begin
                    // Later chunks never carry sub-ns; it went with the first.
                    w_state_nxt   = ST_STEP;
                    w_set_off_nxt = 1'b1;
                    w_off_ns_nxt  = w_rem_step;
                end else begin
                    w_gap_nxt = r_gap - GAP_W'(1);
                end
            end
`endif

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_host_ready <= 1'b1;
            r_dir        <= 1'b0;
            r_set_init   <= 1'b0;
            r_init_sub   <= '0;
            r_init_ns    <= '0;
            r_init_sec   <= '0;
            r_set_off    <= 1'b0;
            r_plus       <= 1'b0;
            r_off_sub    <= '0;
            r_off_ns     <= '0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
`ifdef TOD_ADJ_SLEW_EN
            r_rem        <= '0;
            r_gap        <= '0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_host_ready <= (w_state_nxt == ST_IDLE);
            r_dir        <= w_dir_nxt;
            r_set_init   <= w_set_init_nxt;
            r_init_sub   <= w_init_sub_nxt;
            r_init_ns    <= w_init_ns_nxt;
            r_init_sec   <= w_init_sec_nxt;
            r_set_off    <= w_set_off_nxt;
            r_plus       <= w_plus_nxt;
            r_off_sub    <= w_off_sub_nxt;
            r_off_ns     <= w_off_ns_nxt;
            r_done       <= w_done_nxt;
            r_err        <= w_err_nxt;
`ifdef TOD_ADJ_SLEW_EN
            r_rem        <= w_rem_nxt;
            r_gap        <= w_gap_nxt;
`endif
        end
    end

    // r_host_ready mirrors (state == IDLE); busy is its complement.
    // srv_ready must see host_valid in the same cycle so a simultaneous host
    // request can never be accepted alongside a servo request.
    assign adj.host_ready         = r_host_ready;
    assign adj.srv_ready          = r_host_ready & ~adj.host_valid;
    assign adj.busy               = ~r_host_ready;
    assign adj.set_init_time      = r_set_init;
    assign adj.init_time_sub_ns   = r_init_sub;
    assign adj.init_time_ns       = r_init_ns;
    assign adj.init_time_sec      = r_init_sec;
    assign adj.set_offset_time    = r_set_off;
    assign adj.plus_offset_time   = r_plus;
    assign adj.offset_time_sub_ns = r_off_sub;
    assign adj.offset_time_ns     = r_off_ns;
    assign adj.done               = r_done;
    assign adj.err                = r_err;
`ifdef TOD_ADJ_SLEW_EN
    assign adj.remaining_ns       = r_rem;
`else
    assign adj.remaining_ns       = '0;
`endif

endmodule

// File: tb/tb_tod_adj_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tod_adj_ctrl
// Directed self-checking bench for tod_adj_ctrl (MAX_STEP_NS=1000,
// STEP_GAP=3). Covers both builds selected by TOD_ADJ_SLEW_EN.
// ---------------------------------------------------------------------------
module tb_tod_adj_ctrl;
    localparam int SUBW = 20;
    localparam int NSW  = 32;
    localparam int SECW = 48;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;

    tod_adj_ctrl_if #(
        .TIME_WIDTH_SUB_NS(SUBW),
        .TIME_WIDTH_NS    (NSW),
        .TIME_WIDTH_SEC   (SECW)
    ) bus ();

    tod_adj_ctrl #(
        .TIME_WIDTH_SUB_NS(SUBW),
        .TIME_WIDTH_NS    (NSW),
        .TIME_WIDTH_SEC   (SECW),
        .MAX_STEP_NS      (1000),
        .STEP_GAP         (3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .adj(bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.host_valid   = 1'b0;
        bus.host_is_init = 1'b0;
        bus.host_plus    = 1'b0;
        bus.host_sub_ns  = '0;
        bus.host_ns      = '0;
        bus.host_sec     = '0;
        bus.srv_valid    = 1'b0;
        bus.srv_plus     = 1'b0;
        bus.srv_sub_ns   = '0;
        bus.srv_ns       = '0;
    endtask

    task automatic host_req(input logic is_init, input logic plus, input logic [SECW-1:0] sec,
                            input logic [NSW-1:0] ns, input logic [SUBW-1:0] sub);
        bus.host_valid   = 1'b1;
        bus.host_is_init = is_init;
        bus.host_plus    = plus;
        bus.host_sec     = sec;
        bus.host_ns      = ns;
        bus.host_sub_ns  = sub;
    endtask

    task automatic srv_req(input logic plus, input logic [NSW-1:0] ns, input logic [SUBW-1:0] sub);
        bus.srv_valid  = 1'b1;
        bus.srv_plus   = plus;
        bus.srv_ns     = ns;
        bus.srv_sub_ns = sub;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".set_init"}, 64'(bus.set_init_time), 64'd0);
        chk({tag, ".init_ns"},  64'(bus.init_time_ns), 64'd0);
        chk({tag, ".init_sec"}, 64'(bus.init_time_sec), 64'd0);
        chk({tag, ".set_off"},  64'(bus.set_offset_time), 64'd0);
        chk({tag, ".off_ns"},   64'(bus.offset_time_ns), 64'd0);
        chk({tag, ".off_sub"},  64'(bus.offset_time_sub_ns), 64'd0);
        chk({tag, ".plus"},     64'(bus.plus_offset_time), 64'd0);
        chk({tag, ".done"},     64'(bus.done), 64'd0);
        chk({tag, ".err"},      64'(bus.err), 64'd0);
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;

        // ---------------- reset state ----------------
        tick();
        tick();
        chk_quiet("rst");
        chk("rst.host_ready", 64'(bus.host_ready), 64'd1);
        chk("rst.srv_ready",  64'(bus.srv_ready), 64'd1);
        chk("rst.busy",       64'(bus.busy), 64'd0);
        chk("rst.remaining",  64'(bus.remaining_ns), 64'd0);
        rst = 1'b0;
        tick();

        // ---------------- host init ----------------
        host_req(1'b1, 1'b0, 48'd5, 32'd123, 20'd7);
        #1;
        chk("init.T.srv_ready", 64'(bus.srv_ready), 64'd0);
        chk("init.T.host_ready", 64'(bus.host_ready), 64'd1);
        tick();
        clear_inputs();
        chk("init.T1.set_init", 64'(bus.set_init_time), 64'd1);
        chk("init.T1.sec",      64'(bus.init_time_sec), 64'd5);
        chk("init.T1.ns",       64'(bus.init_time_ns), 64'd123);
        chk("init.T1.sub",      64'(bus.init_time_sub_ns), 64'd7);
        chk("init.T1.done",     64'(bus.done), 64'd1);
        chk("init.T1.busy",     64'(bus.busy), 64'd1);
        chk("init.T1.host_ready", 64'(bus.host_ready), 64'd0);
        chk("init.T1.set_off",  64'(bus.set_offset_time), 64'd0);
        tick();
        chk_quiet("init.T2");
        chk("init.T2.host_ready", 64'(bus.host_ready), 64'd1);
        chk("init.T2.busy",       64'(bus.busy), 64'd0);

        // ---------------- priority: host and servo together ----------------
        host_req(1'b1, 1'b0, 48'd1, 32'd2, 20'd3);
        srv_req(1'b1, 32'd10, 20'd0);
        #1;
        chk("prio.T.srv_ready", 64'(bus.srv_ready), 64'd0);
        tick();
        bus.host_valid = 1'b0;
        chk("prio.T1.set_init", 64'(bus.set_init_time), 64'd1);
        chk("prio.T1.init_ns",  64'(bus.init_time_ns), 64'd2);
        chk("prio.T1.set_off",  64'(bus.set_offset_time), 64'd0);
        chk("prio.T1.srv_ready", 64'(bus.srv_ready), 64'd0);
        tick();
        chk("prio.T2.srv_ready", 64'(bus.srv_ready), 64'd1);
        chk("prio.T2.set_off",   64'(bus.set_offset_time), 64'd0);
        tick();
        clear_inputs();
        chk("prio.T3.set_off", 64'(bus.set_offset_time), 64'd1);
        chk("prio.T3.off_ns",  64'(bus.offset_time_ns), 64'd10);
        chk("prio.T3.plus",    64'(bus.plus_offset_time), 64'd1);
        chk("prio.T3.done",    64'(bus.done), 64'd0);
        tick();
        chk_quiet_done: begin
            chk("prio.T4.done",    64'(bus.done), 64'd1);
            chk("prio.T4.set_off", 64'(bus.set_offset_time), 64'd0);
            chk("prio.T4.plus",    64'(bus.plus_offset_time), 64'd0);
            chk("prio.T4.busy",    64'(bus.busy), 64'd0);
        end
        tick();

        // ---------------- reject ns = 1_000_000_000 ----------------
        host_req(1'b0, 1'b1, 48'd0, 32'd1_000_000_000, 20'd0);
        tick();
        clear_inputs();
        chk("rej.T1.err",     64'(bus.err), 64'd1);
        chk("rej.T1.set_off", 64'(bus.set_offset_time), 64'd0);
        chk("rej.T1.done",    64'(bus.done), 64'd0);
        chk("rej.T1.busy",    64'(bus.busy), 64'd0);
        tick();
        chk_quiet("rej.T2");

        // ---------------- zero offset ----------------
        srv_req(1'b1, 32'd0, 20'd0);
        tick();
        clear_inputs();
        chk("zero.T1.done",    64'(bus.done), 64'd1);
        chk("zero.T1.set_off", 64'(bus.set_offset_time), 64'd0);
        chk("zero.T1.plus",    64'(bus.plus_offset_time), 64'd0);
        tick();
        chk_quiet("zero.T2");

        // ---------------- sub-ns only offset ----------------
        host_req(1'b0, 1'b1, 48'd0, 32'd0, 20'd5);
        tick();
        clear_inputs();
        chk("sub.T1.set_off", 64'(bus.set_offset_time), 64'd1);
        chk("sub.T1.off_ns",  64'(bus.offset_time_ns), 64'd0);
        chk("sub.T1.off_sub", 64'(bus.offset_time_sub_ns), 64'd5);
        chk("sub.T1.plus",    64'(bus.plus_offset_time), 64'd1);
        tick();
        chk("sub.T2.done",    64'(bus.done), 64'd1);
        chk("sub.T2.set_off", 64'(bus.set_offset_time), 64'd0);
        chk("sub.T2.off_sub", 64'(bus.offset_time_sub_ns), 64'd0);
        tick();

`ifdef TOD_ADJ_SLEW_EN
        // ---------------- slew: servo +2500 ns, sub 9 ----------------
        srv_req(1'b1, 32'd2500, 20'd9);
        for (int k = 1; k <= 11; k++) begin
            tick();
            clear_inputs();
            chk($sformatf("slew.T%0d.set_off", k), 64'(bus.set_offset_time),
                (k == 1 || k == 5 || k == 9) ? 64'd1 : 64'd0);
            chk($sformatf("slew.T%0d.off_ns", k), 64'(bus.offset_time_ns),
                (k == 1 || k == 5) ? 64'd1000 : (k == 9) ? 64'd500 : 64'd0);
            chk($sformatf("slew.T%0d.off_sub", k), 64'(bus.offset_time_sub_ns),
                (k == 1) ? 64'd9 : 64'd0);
            chk($sformatf("slew.T%0d.plus", k), 64'(bus.plus_offset_time),
                (k <= 9) ? 64'd1 : 64'd0);
            chk($sformatf("slew.T%0d.done", k), 64'(bus.done),
                (k == 10) ? 64'd1 : 64'd0);
            chk($sformatf("slew.T%0d.busy", k), 64'(bus.busy),
                (k <= 9) ? 64'd1 : 64'd0);
            chk($sformatf("slew.T%0d.remaining", k), 64'(bus.remaining_ns),
                (k == 1) ? 64'd2500 : (k <= 5) ? 64'd1500 : (k <= 9) ? 64'd500 : 64'd0);
        end

        // ---------------- slew aborted by reset between pulses ----------------
        srv_req(1'b1, 32'd2500, 20'd4);
        tick();
        clear_inputs();
        chk("abort.T1.set_off", 64'(bus.set_offset_time), 64'd1);
        chk("abort.T1.off_ns",  64'(bus.offset_time_ns), 64'd1000);
        tick();
        chk("abort.T2.remaining", 64'(bus.remaining_ns), 64'd1500);
        chk("abort.T2.plus",      64'(bus.plus_offset_time), 64'd1);
        chk("abort.T2.host_ready", 64'(bus.host_ready), 64'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_quiet("abort.T3");
        chk("abort.T3.host_ready", 64'(bus.host_ready), 64'd1);
        chk("abort.T3.srv_ready",  64'(bus.srv_ready), 64'd1);
        chk("abort.T3.remaining",  64'(bus.remaining_ns), 64'd0);
        for (int k = 4; k <= 13; k++) begin
            tick();
            chk($sformatf("abort.T%0d.set_off", k), 64'(bus.set_offset_time), 64'd0);
            chk($sformatf("abort.T%0d.done", k), 64'(bus.done), 64'd0);
        end
`else
        // ---------------- single pulse: servo -999_999_999 ----------------
        srv_req(1'b0, 32'd999_999_999, 20'd0);
        tick();
        clear_inputs();
        chk("big.T1.set_off",   64'(bus.set_offset_time), 64'd1);
        chk("big.T1.off_ns",    64'(bus.offset_time_ns), 64'd999_999_999);
        chk("big.T1.plus",      64'(bus.plus_offset_time), 64'd0);
        chk("big.T1.remaining", 64'(bus.remaining_ns), 64'd0);
        chk("big.T1.done",      64'(bus.done), 64'd0);
        tick();
        chk("big.T2.done",    64'(bus.done), 64'd1);
        chk("big.T2.set_off", 64'(bus.set_offset_time), 64'd0);
        tick();

        // ---------------- single pulse: host +2500 ns, sub 9 ----------------
        host_req(1'b0, 1'b1, 48'd0, 32'd2500, 20'd9);
        tick();
        clear_inputs();
        chk("one.T1.set_off", 64'(bus.set_offset_time), 64'd1);
        chk("one.T1.off_ns",  64'(bus.offset_time_ns), 64'd2500);
        chk("one.T1.off_sub", 64'(bus.offset_time_sub_ns), 64'd9);
        chk("one.T1.plus",    64'(bus.plus_offset_time), 64'd1);
        chk("one.T1.busy",    64'(bus.busy), 64'd1);
        tick();
        chk("one.T2.done",    64'(bus.done), 64'd1);
        chk("one.T2.plus",    64'(bus.plus_offset_time), 64'd0);
        chk("one.T2.busy",    64'(bus.busy), 64'd0);
        tick();

        // ---------------- reset during the pulse suppresses done ----------------
        srv_req(1'b1, 32'd77, 20'd0);
        tick();
        clear_inputs();
        chk("abort.T1.set_off", 64'(bus.set_offset_time), 64'd1);
        chk("abort.T1.off_ns",  64'(bus.offset_time_ns), 64'd77);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_quiet("abort.T2");
        chk("abort.T2.host_ready", 64'(bus.host_ready), 64'd1);
        tick();
        chk("abort.T3.done",    64'(bus.done), 64'd0);
        chk("abort.T3.set_off", 64'(bus.set_offset_time), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
